// File: rtl/inv_state.sv
// inv_state: AES-128 inverse-cipher round sequencer; INV_KEY_PRE_EN adds the KEY pre-pass.
module inv_state (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  output logic [2:0] cs,
  output logic [7:0] cot,
  output logic       busy,
  output logic       done,
  output logic       key_we
);
  typedef enum logic [2:0] {
    IDL = 3'b000,
    ADD = 3'b001,
    ISB = 3'b010,
    KEY = 3'b011,
    ISH = 3'b100,
    IMX = 3'b101,
    FIN = 3'b111
  } state_t;
  logic [2:0] r_cs;
  logic [7:0] r_cot;
  always_ff @(posedge clk) begin
    if (res) begin
      r_cs  <= IDL;
      r_cot <= 8'd0;
    end else begin
      case (r_cs)
        IDL: if (start) begin
`ifdef INV_KEY_PRE_EN
          r_cs  <= KEY;
          r_cot <= 8'd0;
`else
          r_cs  <= ADD;
          r_cot <= 8'd10;
`endif
        end
`ifdef INV_KEY_PRE_EN
        KEY: begin
          r_cot <= r_cot + 8'd1;
          if (r_cot == 8'd9) r_cs <= ADD;
        end
`endif
        ADD: begin
          if (r_cot == 8'd0) r_cs <= FIN;
          else if (r_cot == 8'd10) begin
            r_cs  <= ISH;
            r_cot <= 8'd9;
          end else r_cs <= IMX;
        end
        IMX: begin
          r_cs <= ISH;
          if (r_cot != 8'd0) r_cot <= r_cot - 8'd1;
        end
        ISH: r_cs <= ISB;
        ISB: r_cs <= ADD;
        FIN: begin
          r_cs  <= IDL;
          r_cot <= 8'd0;
        end
        default: begin
          r_cs  <= IDL;
          r_cot <= 8'd0;
        end
      endcase
    end
  end
  always_comb begin
    cs   = r_cs;
    cot  = r_cot;
    busy = (r_cs != IDL) && (r_cs != FIN);
    done = r_cs == FIN;
`ifdef INV_KEY_PRE_EN
    key_we = r_cs == KEY;
`else
    key_we = 1'b0;
`endif
  end
endmodule

// File: tb/tb_inv_state.sv
// tb_inv_state: scoreboard bench for inv_state; honours INV_KEY_PRE_EN like the design.
module tb_inv_state;
  localparam logic [2:0] IDL = 3'b000, ADD = 3'b001, ISB = 3'b010, KEY = 3'b011,
                         ISH = 3'b100, IMX = 3'b101, FIN = 3'b111;
  typedef struct packed {
    logic [2:0] cs;
    logic [7:0] cot;
    logic       busy;
    logic       done;
    logic       kwe;
  } exp_t;
  logic clk = 1'b0, res, start;
  logic [2:0] cs;
  logic [7:0] cot;
  logic busy, done, key_we;
  exp_t q[$];
  exp_t tr[$];
  int checks = 0, errors = 0;
  int idx_isb5, idx_add5, idx_fin;
  inv_state dut (
    .clk(clk), .res(res), .start(start), .cs(cs), .cot(cot),
    .busy(busy), .done(done), .key_we(key_we)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(input logic [2:0] s, input int c);
    exp_t e;
    e.cs   = s;
    e.cot  = 8'(c);
    e.busy = (s != IDL) && (s != FIN);
    e.done = s == FIN;
`ifdef INV_KEY_PRE_EN
    e.kwe  = s == KEY;
`else
    e.kwe  = 1'b0;
`endif
    return e;
  endfunction
  task automatic step(input logic s, input logic r, input exp_t e);
    @(negedge clk);
    start = s;
    res   = r;
    q.push_back(e);
  endtask
  task automatic run(input logic hold, input int n);
    for (int i = 0; i < n; i++) step(i == 0 ? 1'b1 : hold, 1'b0, tr[i]);
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({cs, cot, busy, done, key_we} !== e) begin
        errors++;
        $display("FAIL state#%0d: got cs=%b cot=%0d busy=%b done=%b key_we=%b, want cs=%b cot=%0d busy=%b done=%b key_we=%b",
                 checks, cs, cot, busy, done, key_we, e.cs, e.cot, e.busy, e.done, e.kwe);
      end
    end
  end
  initial begin
`ifdef INV_KEY_PRE_EN
    for (int i = 0; i < 10; i++) tr.push_back(mk(KEY, i));
`endif
    tr.push_back(mk(ADD, 10));
    for (int r = 9; r >= 1; r--) begin
      tr.push_back(mk(ISH, r));
      tr.push_back(mk(ISB, r));
      tr.push_back(mk(ADD, r));
      tr.push_back(mk(IMX, r));
    end
    tr.push_back(mk(ISH, 0));
    tr.push_back(mk(ISB, 0));
    tr.push_back(mk(ADD, 0));
    tr.push_back(mk(FIN, 0));
    tr.push_back(mk(IDL, 0));
    foreach (tr[i]) begin
      if (tr[i].cs == ISB && tr[i].cot == 8'd5) idx_isb5 = i;
      if (tr[i].cs == ADD && tr[i].cot == 8'd5) idx_add5 = i;
      if (tr[i].cs == FIN) idx_fin = i;
    end
`ifdef INV_KEY_PRE_EN
    if (idx_fin != 50) $display("FAIL latency: trace puts FIN at %0d, want 50", idx_fin);
`else
    if (idx_fin != 40) $display("FAIL latency: trace puts FIN at %0d, want 40", idx_fin);
`endif
    res = 1'b1;
    start = 1'b0;
    step(1'b1, 1'b1, mk(IDL, 0));
    step(1'b0, 1'b1, mk(IDL, 0));
    repeat (3) step(1'b0, 1'b0, mk(IDL, 0));
    run(1'b0, tr.size());
    step(1'b0, 1'b0, mk(IDL, 0));
    run(1'b1, tr.size());
    run(1'b0, tr.size());
    step(1'b0, 1'b0, mk(IDL, 0));
    run(1'b0, idx_isb5 + 1);
    step(1'b0, 1'b1, mk(IDL, 0));
    repeat (3) step(1'b0, 1'b0, mk(IDL, 0));
    run(1'b0, tr.size());
    run(1'b0, idx_add5 + 1);
    @(negedge clk);
    force dut.r_cs = 3'b110;
    #1 release dut.r_cs;
    q.push_back(mk(IDL, 0));
    step(1'b0, 1'b0, mk(IDL, 0));
    step(1'b0, 1'b0, mk(IDL, 0));
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/inv_state.md
INV_STATE -- requirements
Module: inv_state

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, res.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 res  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 start  input  1  start one AES-128 inverse-cipher run; sampled only in IDL.
REQ-005 cs  output  3  current state code: IDL 3'b000, ADD 3'b001, ISB 3'b010, KEY 3'b011, ISH 3'b100, IMX 3'b101, FIN 3'b111.
REQ-006 cot  output  8  round index driving the round-key select and datapath muxing.
REQ-007 busy  output  1  high in every state except IDL and FIN.
REQ-008 done  output  1  high exactly while cs==FIN.
REQ-009 key_we  output  1  high exactly while cs==KEY; round key cot+1 is written that cycle.

Function
REQ-010 The block SHALL sequence the inverse cipher: AddRoundKey(rk10); rounds 9..1 {InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns}; round 0 {InvShiftRows, InvSubBytes, AddRoundKey}.
REQ-011 IDL: start=1 -> KEY with cot<=0 if INV_KEY_PRE_EN is defined, else ADD with cot<=10; start=0 -> stay IDL, cot unchanged.
REQ-012 KEY: cot<=cot+1 every cycle; cot==9 -> ADD (cot becomes 10), else stay KEY; exactly 10 cycles are spent in KEY.
REQ-013 ADD: cot==0 -> FIN; cot==10 -> ISH with cot<=9; otherwise -> IMX with cot unchanged.
REQ-014 IMX -> ISH with cot<=cot-1.
REQ-015 ISH -> ISB; ISB -> ADD; cot unchanged in both.
REQ-016 FIN -> IDL unconditionally after one cycle, so done is a single-cycle pulse; cot holds 0 in FIN and IDL.
REQ-017 The block SHALL ignore start in every state except IDL, including a start asserted during FIN.
REQ-018 An unused code (3'b110) SHALL go to IDL with cot<=0 on the next edge.
REQ-019 cot SHALL never wrap: its range is 0..10, and no decrement is issued at cot==0.
REQ-020 Latency from the edge sampling start to the first cycle with cs==FIN SHALL be 50 cycles with INV_KEY_PRE_EN defined and 40 without it.
REQ-021 All outputs SHALL be registered or decoded from registered cs only; there is no combinational path from start to any output.

Reset
REQ-022 With res=1 at a rising clk edge, the block SHALL set cs<=IDL and cot<=0, so busy=0, done=0 and key_we=0.
REQ-023 Reset SHALL take priority over start and over any in-progress run; an aborted run SHALL NOT produce done.
REQ-024 After res is released, the block SHALL stay in IDL until start=1 is sampled.

Configuration
REQ-025 Macro INV_KEY_PRE_EN defined: each run SHALL begin with the 10-cycle KEY pre-pass generating round keys 1..10 before the first ADD.
REQ-026 Macro INV_KEY_PRE_EN undefined: the KEY state and the key_we assertion SHALL be absent; key_we SHALL be tied 0; round keys are supplied pre-expanded; IDL goes directly to ADD with cot=10.

Verification
REQ-027 Reset, then start pulse for 1 cycle (EN defined) -> KEY for 10 cycles with cot 0..9 and key_we=1; ADD with cot=10; FIN 50 cycles after the start edge; done=1 for exactly 1 cycle; IDL with cot=0.
REQ-028 Same stimulus with EN undefined -> ADD with cot=10 on the first edge; key_we always 0; FIN after 40 cycles.
REQ-029 Trace check -> cs/cot follow ADD10, ISH9, ISB9, ADD9, IMX9, ISH8 ... ADD1, IMX1, ISH0, ISB0, ADD0, FIN; IMX never appears with cot 10 or 0.
REQ-030 Start held high for the whole run -> exactly one run; with start still high in FIN, the next run begins only after returning to IDL; no extra done pulse.
REQ-031 res=1 asserted while cs==ISB, cot==5 -> next cycle cs=IDL, cot=0, busy=0; no done pulse; a new start runs the full latency.
REQ-032 Force cs to 3'b110 -> next cycle IDL, cot=0.
